// File: rtl/cmpalu_seq.sv
// Sequencer for the bitmap compare ALU: fetches a column-major glyph, streams columns and
// transposed rows to the ALU, returns its result. Optional `CMPSEQ_SKIP_EMPTY_EN` short-cuts empty glyphs.
module cmpalu_seq #(
  parameter int NCOLS          = 24,
  parameter int NROWS          = 64,
  parameter int AW             = 16,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AW-1:0]    base_addr,
  output logic             busy,
  output logic             res_valid,
  output logic [15:0]      res,
  output logic             res_err,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_addr,
  input  logic [NROWS-1:0] mem_rdata,
  input  logic             mem_valid,
  output logic             alu_start,
  output logic [NROWS-1:0] alu_bitcolumn,
  output logic [NCOLS-1:0] alu_bitrowtop,
  output logic [NCOLS-1:0] alu_bitrowbot,
  output logic             alu_nextcolumnready,
  output logic             alu_nextrowtopready,
  output logic             alu_nextrowbotready,
  output logic             alu_lastcolumn,
  input  logic [15:0]      alu_result,
  input  logic             alu_done,
  input  logic             alu_nextcolumn,
  input  logic             alu_nextrowtop,
  input  logic             alu_nextrowbot,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(NCOLS);
  localparam int RW = $clog2(NROWS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(NCOLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NROWS - 1);
  localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_PRIME  = 3'd3,
    S_STREAM = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  state_t              state;
  logic [AW-1:0]       base_q;
  logic [CW-1:0]       idx;
  logic                rd_pend;
  logic [NROWS-1:0]    col_buf [NCOLS];
  logic [CW-1:0]       col_idx;
  logic [RW-1:0]       top_idx;
  logic [RW-1:0]       bot_idx;
  logic                done_seen;
  logic [15:0]         res_cap;
  logic [TW-1:0]       tcnt;
`ifdef CMPSEQ_SKIP_EMPTY_EN
  logic                any_set;
`endif

  logic                buf_we;
  logic [CW-1:0]       col_sel;
  logic [RW-1:0]       top_sel;
  logic [RW-1:0]       bot_sel;
  logic [NCOLS-1:0]    top_row;
  logic [NCOLS-1:0]    bot_row;
  logic                col_go, top_go, bot_go, all_done, last_hit;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign buf_we    = (state == S_LOAD) && rd_pend && mem_valid;

  // ALU handshake: alu_next* = 1 means the ALU has checked the item last loaded; a one-cycle
  // *ready pulse loads new stable data. The flag is stale in the pulse cycle, so no back-to-back pulses.
  assign col_go   = alu_nextcolumn && !alu_nextcolumnready && (col_idx != COL_LAST);
  assign top_go   = alu_nextrowtop && !alu_nextrowtopready && (top_idx != ROW_LAST);
  assign bot_go   = alu_nextrowbot && !alu_nextrowbotready && (bot_idx != '0);
  assign all_done = (col_idx == COL_LAST) && (top_idx == ROW_LAST) && (bot_idx == '0);
  assign last_hit = (col_idx == COL_LAST) && alu_nextcolumn && !alu_nextcolumnready;

  always_comb begin
    col_sel = '0;
    top_sel = '0;
    bot_sel = ROW_LAST;
    if (state == S_STREAM) begin
      col_sel = col_idx + CW'(1);
      top_sel = top_idx + RW'(1);
      bot_sel = bot_idx - RW'(1);
    end
  end

  // Row r of the glyph is bit r of every column word.
  always_comb begin
    top_row = '0;
    bot_row = '0;
    for (int c = 0; c < NCOLS; c++) begin
      top_row[c] = col_buf[c][top_sel];
      bot_row[c] = col_buf[c][bot_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) col_buf[idx] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      base_q              <= '0;
      idx                 <= '0;
      rd_pend             <= 1'b0;
      col_idx             <= '0;
      top_idx             <= '0;
      bot_idx             <= '0;
      done_seen           <= 1'b0;
      res_cap             <= '0;
      tcnt                <= '0;
      res_valid           <= 1'b0;
      res                 <= '0;
      res_err             <= 1'b0;
      mem_rd              <= 1'b0;
      mem_addr            <= '0;
      alu_start           <= 1'b0;
      alu_bitcolumn       <= '0;
      alu_bitrowtop       <= '0;
      alu_bitrowbot       <= '0;
      alu_nextcolumnready <= 1'b0;
      alu_nextrowtopready <= 1'b0;
      alu_nextrowbotready <= 1'b0;
      alu_lastcolumn      <= 1'b0;
`ifdef CMPSEQ_SKIP_EMPTY_EN
      any_set             <= 1'b0;
`endif
    end else begin
      mem_rd              <= 1'b0;
      alu_start           <= 1'b0;
      res_valid           <= 1'b0;
      alu_nextcolumnready <= 1'b0;
      alu_nextrowtopready <= 1'b0;
      alu_nextrowbotready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            base_q  <= base_addr;
            idx     <= '0;
            rd_pend <= 1'b0;
`ifdef CMPSEQ_SKIP_EMPTY_EN
            any_set <= 1'b0;
`endif
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!rd_pend) begin
            mem_rd   <= 1'b1;
            mem_addr <= base_q + AW'(idx);
            rd_pend  <= 1'b1;
          end else if (mem_valid) begin
            rd_pend <= 1'b0;
`ifdef CMPSEQ_SKIP_EMPTY_EN
            any_set <= any_set | (|mem_rdata);
`endif
            if (idx == COL_LAST) begin
`ifdef CMPSEQ_SKIP_EMPTY_EN
              if (!(any_set || (|mem_rdata))) begin
                res       <= '0;
                res_err   <= 1'b0;
                res_valid <= 1'b1;
                state     <= S_IDLE;
              end else begin
                alu_start <= 1'b1;
                state     <= S_START;
              end
`else
              alu_start <= 1'b1;
              state     <= S_START;
`endif
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        S_START: begin
          // Prime all channels: the ALU's checked flags are stale right after start.
          alu_bitcolumn       <= col_buf[0];
          alu_bitrowtop       <= top_row;
          alu_bitrowbot       <= bot_row;
          alu_nextcolumnready <= 1'b1;
          alu_nextrowtopready <= 1'b1;
          alu_nextrowbotready <= 1'b1;
          col_idx             <= '0;
          top_idx             <= '0;
          bot_idx             <= ROW_LAST;
          done_seen           <= 1'b0;
          state               <= S_PRIME;
        end
        S_PRIME: begin
          if (alu_done) begin
            done_seen <= 1'b1;
            res_cap   <= alu_result;
          end
          state <= S_STREAM;
        end
        S_STREAM: begin
          if (alu_done) begin
            done_seen <= 1'b1;
            res_cap   <= alu_result;
          end
          if (col_go) begin
            alu_bitcolumn       <= col_buf[col_sel];
            alu_nextcolumnready <= 1'b1;
            col_idx             <= col_idx + CW'(1);
          end
          if (top_go) begin
            alu_bitrowtop       <= top_row;
            alu_nextrowtopready <= 1'b1;
            top_idx             <= top_idx + RW'(1);
          end
          if (bot_go) begin
            alu_bitrowbot       <= bot_row;
            alu_nextrowbotready <= 1'b1;
            bot_idx             <= bot_idx - RW'(1);
          end
          if (last_hit) alu_lastcolumn <= 1'b1;
          if (all_done) begin
            if (done_seen || alu_done) begin
              res            <= done_seen ? res_cap : alu_result;
              res_err        <= 1'b0;
              res_valid      <= 1'b1;
              alu_lastcolumn <= 1'b0;
              state          <= S_IDLE;
            end else begin
              tcnt  <= '0;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (last_hit) alu_lastcolumn <= 1'b1;
          if (alu_done) begin
            res            <= alu_result;
            res_err        <= 1'b0;
            res_valid      <= 1'b1;
            alu_lastcolumn <= 1'b0;
            state          <= S_IDLE;
          end else if (tcnt == TO_LIM) begin
            res            <= '0;
            res_err        <= 1'b1;
            res_valid      <= 1'b1;
            alu_lastcolumn <= 1'b0;
            state          <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmpalu_seq.sv
// Bench for cmpalu_seq: memory and ALU responders, reference result from the glyph geometry.
module tb_cmpalu_seq;
  localparam int NC = 24;
  localparam int NR = 64;
  localparam int TO = 512;

  logic        clk = 1'b0;
  logic        rst, req;
  logic [15:0] base_addr;
  logic        busy, res_valid, res_err, mem_rd, mem_valid, alu_start, alu_lastcolumn;
  logic [15:0] res, mem_addr, alu_result;
  logic [63:0] mem_rdata, alu_bitcolumn;
  logic [23:0] alu_bitrowtop, alu_bitrowbot;
  logic        alu_nextcolumnready, alu_nextrowtopready, alu_nextrowbotready;
  logic        alu_done, alu_nextcolumn, alu_nextrowtop, alu_nextrowbot;
  logic [2:0]  dbg_state;

  cmpalu_seq dut (
    .clk(clk), .rst(rst), .req(req), .base_addr(base_addr), .busy(busy),
    .res_valid(res_valid), .res(res), .res_err(res_err),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .alu_start(alu_start), .alu_bitcolumn(alu_bitcolumn),
    .alu_bitrowtop(alu_bitrowtop), .alu_bitrowbot(alu_bitrowbot),
    .alu_nextcolumnready(alu_nextcolumnready), .alu_nextrowtopready(alu_nextrowtopready),
    .alu_nextrowbotready(alu_nextrowbotready), .alu_lastcolumn(alu_lastcolumn),
    .alu_result(alu_result), .alu_done(alu_done), .alu_nextcolumn(alu_nextcolumn),
    .alu_nextrowtop(alu_nextrowtop), .alu_nextrowbot(alu_nextrowbot), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [63:0] mem_img [NC];
  int n_cmp = 0, n_bad = 0;

  // responder / monitor bookkeeping
  int rd_n, addr_err, order_err, lat_lo, lat_hi;
  bit spur_en, early_en;
  logic [15:0] base_exp;
  int col_n, top_n, bot_n, start_n, consec_err, data_err;
  bit last_seen;
  logic [63:0] rx_col [NC];
  logic [23:0] rx_top [NR];
  logic [23:0] rx_bot [NR];
  int rv_n, cyc, rv_cyc, last_strobe_cyc;
  logic [15:0] res_cap;
  logic err_cap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] trow(input int r);
    logic [23:0] v;
    for (int c = 0; c < NC; c++) v[c] = mem_img[c][r];
    return v;
  endfunction

  // Expected result from glyph geometry: [4:0] left shift, [10:5] down shift,
  // [11] width fits half, [12] height fits half; bit 16 flags a non-empty glyph.
  function automatic logic [16:0] ref_res();
    int cmin = 99, cmax = -1, rmin = 99, rmax = -1;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (mem_img[c][r]) begin
          if (c < cmin) cmin = c;
          if (c > cmax) cmax = c;
          if (r < rmin) rmin = r;
          if (r > rmax) rmax = r;
        end
    if (cmax < 0) return '0;
    return {1'b1, 3'b000, (rmax - rmin + 1) <= NR / 2, (cmax - cmin + 1) <= NC / 2,
            6'(NR - 1 - rmax), 5'(cmin)};
  endfunction

  // What the ALU computes from the items it actually received.
  function automatic logic [16:0] alu_calc();
    int l = -1, cm = -1, t0 = -1, k = -1;
    for (int i = 0; i < NC; i++)
      if (rx_col[i] != 0) begin
        if (l < 0) l = i;
        cm = i;
      end
    for (int i = 0; i < NR; i++) begin
      if (t0 < 0 && rx_top[i] != 0) t0 = i;
      if (k < 0 && rx_bot[i] != 0) k = i;
    end
    if (l < 0 || t0 < 0 || k < 0) return '0;
    return {1'b1, 3'b000, ((NR - 1 - k) - t0 + 1) <= NR / 2, (cm - l + 1) <= NC / 2,
            6'(k), 5'(l)};
  endfunction

  // memory responder: one read at a time, random latency, optional stray valids
  initial begin
    bit pend;
    int lat;
    logic [15:0] ridx;
    mem_valid = 1'b0;
    mem_rdata = '0;
    pend = 0;
    lat = 0;
    ridx = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (rst) begin
        pend = 0;
        continue;
      end
      if (mem_rd) begin
        if (pend) order_err++;
        if (mem_addr !== base_exp + 16'(rd_n)) addr_err++;
        pend = 1;
        lat = $urandom_range(lat_hi, lat_lo);
        ridx = mem_addr - base_exp;
        rd_n++;
      end
      if (pend) begin
        if (lat == 0) begin
          mem_valid = 1'b1;
          mem_rdata = (int'(ridx) < NC) ? mem_img[ridx[4:0]] : '1;
          pend = 0;
        end else begin
          lat--;
        end
      end else if (spur_en && $urandom_range(3, 0) == 0) begin
        mem_valid = 1'b1;
        mem_rdata = {$urandom, $urandom};
      end
    end
  end

  // ALU responder
  initial begin
    int dly_c, dly_t, dly_b, done_cnt;
    bit pv_c, pv_t, pv_b, started, done_sent, ready_now;
    logic [16:0] cv;
    alu_done = 1'b0; alu_result = '0;
    alu_nextcolumn = 1'b0; alu_nextrowtop = 1'b0; alu_nextrowbot = 1'b0;
    dly_c = 0; dly_t = 0; dly_b = 0; done_cnt = -1;
    pv_c = 0; pv_t = 0; pv_b = 0; started = 0; done_sent = 0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (rst) begin
        alu_nextcolumn = 1'b0; alu_nextrowtop = 1'b0; alu_nextrowbot = 1'b0;
        pv_c = 0; pv_t = 0; pv_b = 0; started = 0;
        continue;
      end
      if (alu_start) begin
        start_n++;
        started = 1; done_sent = 0; done_cnt = -1;
        alu_nextcolumn = 1'b1; alu_nextrowtop = 1'b1; alu_nextrowbot = 1'b1;
      end
      if (alu_nextcolumnready) begin
        if (pv_c) consec_err++;
        if (col_n < NC) begin
          rx_col[col_n] = alu_bitcolumn;
          if (alu_bitcolumn !== mem_img[col_n]) data_err++;
        end else data_err++;
        col_n++;
        alu_nextcolumn = 1'b0;
        dly_c = $urandom_range(3, 0);
      end else if (!alu_nextcolumn) begin
        if (dly_c == 0) alu_nextcolumn = 1'b1; else dly_c--;
      end
      pv_c = alu_nextcolumnready;
      if (alu_nextrowtopready) begin
        if (pv_t) consec_err++;
        if (top_n < NR) begin
          rx_top[top_n] = alu_bitrowtop;
          if (alu_bitrowtop !== trow(top_n)) data_err++;
        end else data_err++;
        top_n++;
        alu_nextrowtop = 1'b0;
        dly_t = $urandom_range(3, 0);
      end else if (!alu_nextrowtop) begin
        if (dly_t == 0) alu_nextrowtop = 1'b1; else dly_t--;
      end
      pv_t = alu_nextrowtopready;
      if (alu_nextrowbotready) begin
        if (pv_b) consec_err++;
        if (bot_n < NR) begin
          rx_bot[bot_n] = alu_bitrowbot;
          if (alu_bitrowbot !== trow(NR - 1 - bot_n)) data_err++;
        end else data_err++;
        bot_n++;
        alu_nextrowbot = 1'b0;
        dly_b = $urandom_range(3, 0);
      end else if (!alu_nextrowbot) begin
        if (dly_b == 0) alu_nextrowbot = 1'b1; else dly_b--;
      end
      pv_b = alu_nextrowbotready;
      if (alu_lastcolumn) begin
        last_seen = 1;
        if (col_n < NC) data_err++;
      end
      if (started && !done_sent) begin
        ready_now = early_en ? (col_n >= 4) : (col_n == NC && top_n == NR && bot_n == NR);
        cv = early_en ? ref_res() : alu_calc();
        if (ready_now && cv[16]) begin
          if (done_cnt < 0) done_cnt = $urandom_range(4, 0);
          if (done_cnt == 0) begin
            alu_done = 1'b1;
            alu_result = cv[15:0];
            done_sent = 1;
          end else done_cnt--;
        end
      end
    end
  end

  // result monitor
  initial begin
    cyc = 0; rv_n = 0; rv_cyc = 0; last_strobe_cyc = 0; res_cap = '0; err_cap = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        rv_n++;
        res_cap = res;
        err_cap = res_err;
        rv_cyc = cyc;
      end
      if (alu_nextcolumnready || alu_nextrowtopready || alu_nextrowbotready) last_strobe_cyc = cyc;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    rd_n = 0; addr_err = 0; order_err = 0; col_n = 0; top_n = 0; bot_n = 0;
    start_n = 0; consec_err = 0; data_err = 0; last_seen = 0; rv_n = 0;
  endtask

  task automatic set_pixel(input int c, input int r);
    for (int i = 0; i < NC; i++) mem_img[i] = '0;
    mem_img[c][r] = 1'b1;
  endtask

  task automatic set_random();
    int c0, w, r0, h;
    c0 = $urandom_range(NC - 1, 0);
    w  = $urandom_range(NC - c0, 1);
    r0 = $urandom_range(NR - 1, 0);
    h  = $urandom_range(NR - r0, 1);
    for (int i = 0; i < NC; i++) mem_img[i] = '0;
    for (int c = c0; c < c0 + w; c++)
      for (int r = r0; r < r0 + h; r++) mem_img[c][r] = 1'($urandom_range(1, 0));
    mem_img[c0][r0] = 1'b1;
  endtask

  task automatic start_req(input logic [15:0] base);
    base_exp = base;
    @(posedge clk); #1;
    req = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    req = 1'b0;
    base_addr = 16'($urandom);
  endtask

  task automatic run_job(input string tag, input logic [15:0] base, input int llo, input int lhi,
                         input bit spur, input bit early, input bit poke);
    logic [16:0] e;
    bit empty, alu_used, exp_err;
    int d;
    e = ref_res();
    empty = !e[16];
`ifdef CMPSEQ_SKIP_EMPTY_EN
    alu_used = !empty;
    exp_err = 1'b0;
`else
    alu_used = 1'b1;
    exp_err = empty;
`endif
    clear_counts();
    lat_lo = llo; lat_hi = lhi; spur_en = spur; early_en = early;
    start_req(base);
    if (poke) begin
      repeat (40) @(posedge clk);
      #1 req = 1'b1;
      base_addr = base + 16'h0100;
      @(posedge clk); #1 req = 1'b0;
    end
    for (int i = 0; i < 4000 && rv_n == 0; i++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_nvalid"}, 32'(rv_n), 32'd1);
    check({tag, "_res"}, 32'(res_cap), 32'(e[15:0]));
    check({tag, "_err"}, 32'(err_cap), 32'(exp_err));
    check({tag, "_nrd"}, 32'(rd_n), 32'(NC));
    check({tag, "_addr"}, 32'(addr_err), 32'd0);
    check({tag, "_order"}, 32'(order_err), 32'd0);
    check({tag, "_nstart"}, 32'(start_n), 32'(alu_used));
    if (alu_used) begin
      check({tag, "_ncol"}, 32'(col_n), 32'(NC));
      check({tag, "_ntop"}, 32'(top_n), 32'(NR));
      check({tag, "_nbot"}, 32'(bot_n), 32'(NR));
      check({tag, "_consec"}, 32'(consec_err), 32'd0);
      check({tag, "_data"}, 32'(data_err), 32'd0);
      check({tag, "_lastcol"}, 32'(last_seen), 32'd1);
    end
    if (exp_err) begin
      d = rv_cyc - last_strobe_cyc;
      check({tag, "_tolat"}, 32'(d >= TO && d <= TO + 4), 32'd1);
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; base_addr = '0; base_exp = '0;
    lat_lo = 1; lat_hi = 1; spur_en = 0; early_en = 0;
    for (int i = 0; i < NC; i++) mem_img[i] = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'(|{busy, res_valid, res, res_err, mem_rd, mem_addr, alu_start,
          alu_bitcolumn, alu_bitrowtop, alu_bitrowbot, alu_nextcolumnready,
          alu_nextrowtopready, alu_nextrowbotready, alu_lastcolumn}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    set_pixel(5, 10);
    run_job("px5_10_lat1", 16'h1000, 1, 1, 0, 0, 0);
    check("px5_10_value", 32'(res_cap), 32'h1EA5);

    set_pixel(0, 63);
    run_job("px0_63", 16'h0040, 0, 3, 0, 0, 0);
    check("px0_63_value", 32'(res_cap), 32'h1800);

    for (int i = 0; i < NC; i++) mem_img[i] = '1;
    run_job("ones_lat0", 16'h2000, 0, 0, 0, 0, 0);
    check("ones_value", 32'(res_cap), 32'h0000);

    set_pixel(5, 10);
    run_job("px_rand_lat", 16'hFFF0, 0, 7, 1, 0, 1);
    check("px_rand_value", 32'(res_cap), 32'h1EA5);

    set_random();
    run_job("early_done", 16'h0300, 0, 2, 0, 1, 0);

    for (int k = 0; k < 3; k++) begin
      set_random();
      run_job($sformatf("rand%0d", k), 16'($urandom), 0, 5, 1, 0, 0);
    end

    for (int i = 0; i < NC; i++) mem_img[i] = '0;
    run_job("empty", 16'h0500, 0, 2, 0, 0, 0);

    // abort mid-stream, then a fresh job
    set_pixel(5, 10);
    clear_counts();
    lat_lo = 0; lat_hi = 2; spur_en = 0; early_en = 0;
    start_req(16'h0600);
    for (int i = 0; i < 2000 && top_n < 10; i++) @(posedge clk);
    check("abort_reach", 32'(top_n >= 10), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_outs", 32'(|{busy, res_valid, res, res_err, mem_rd, mem_addr, alu_start,
          alu_bitcolumn, alu_bitrowtop, alu_bitrowbot, alu_nextcolumnready,
          alu_nextrowtopready, alu_nextrowbotready, alu_lastcolumn}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("abort_novalid", 32'(rv_n), 32'd0);
    set_pixel(7, 20);
    run_job("after_abort", 16'h0700, 0, 4, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmpalu_seq.md
Name: cmpalu_seq

Overview:
Sequencer for the bitmap compare ALU.
- Fetches one 24-column x 64-row glyph bitmap from word memory. Each 64-bit word is one column; word 0 is the leftmost column.
- Buffers the bitmap internally and drives the ALU's start / column / row handshakes.
- Returns the 16-bit shift/scale result to the requester, with a timeout guard.
- Sits between the render-scheduler request port and the compare ALU.

Parameters:
NCOLS, 24, columns per bitmap (words fetched)
NROWS, 64, rows per bitmap (bit width of a column word)
AW, 16, memory address width
TIMEOUT_CYCLES, 512, cycles allowed in WAIT_DONE before an error is reported

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  1  request; sampled only in IDLE
base_addr  in  AW  address of column 0
busy  out  1  high in any state other than IDLE
res_valid  out  1  one-cycle pulse; res/res_err are valid
res  out  16  ALU result as captured
res_err  out  1  timeout flag, qualified by res_valid
mem_rd  out  1  one-cycle read strobe
mem_addr  out  AW  read address
mem_rdata  in  64  read data
mem_valid  in  1  read data valid, arbitrary latency
alu_start  out  1  ALU clear pulse
alu_bitcolumn  out  64  column data
alu_bitrowtop  out  24  top-walk row
alu_bitrowbot  out  24  bottom-walk row
alu_nextcolumnready / alu_nextrowtopready / alu_nextrowbotready  out  1 each  load strobes
alu_lastcolumn  out  1  final column consumed
alu_result  in  16  ALU result
alu_done  in  1  ALU finished
alu_nextcolumn / alu_nextrowtop / alu_nextrowbot  in  1 each  ALU has checked the current item

Behaviour:
Reset and general:
- Single clock domain: clk. rst is synchronous and active-high.
- On reset, all outputs are 0 and the FSM is in IDLE.
- Reset mid-operation aborts immediately. No res_valid is issued, and any late mem_valid is ignored.

State machine:
- IDLE: on req=1, latch base_addr, clear the word index, go to LOAD.
- LOAD: one read outstanding at a time.
  - Pulse mem_rd with mem_addr = base + idx.
  - On mem_valid, store the word in buf[idx] and increment idx.
  - After word NCOLS-1 is stored, go to START.
  - mem_valid without an outstanding read is ignored.
- START: alu_start=1 for exactly one cycle, then go to PRIME.
- PRIME: one cycle.
  - Present col 0, row 0 (top) and row 63 (bottom).
  - Pulse all three ready strobes unconditionally, because the ALU's checked flags are stale after start.
  - Go to STREAM.
- STREAM: channels run independently.
  - A channel issues its next item (data stable plus a one-cycle ready pulse) when its alu_next* is 1 and it did not pulse in the previous cycle.
  - Column channel walks 0..NCOLS-1.
  - Top row channel walks 0..63; bottom row channel walks 63..0.
  - Row r is the transpose: bit c = buf[c][r], c = 0..23.
  - Data outputs hold their last value between pulses.
  - An exhausted channel issues nothing more.
  - When the column channel is exhausted and alu_nextcolumn=1, set alu_lastcolumn and hold it until return to IDLE.
  - Go to WAIT_DONE once all three channels are exhausted.
- WAIT_DONE: the cycle counter starts at 0 on entry.
  - On alu_done=1: res <= alu_result, res_err=0, res_valid pulse, go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES: res=0, res_err=1, res_valid pulse, go to IDLE.
  - alu_done seen while still in STREAM: capture the result, finish remaining channel items, then report without waiting.

Other rules:
- req while busy is ignored; no queueing.
- res/res_err hold their value until the next report.
- Index counters use ceil(log2) width with no wrap; the terminal index is compared explicitly.

Optional Feature:
CMPSEQ_SKIP_EMPTY_EN
- Enabled: during LOAD, OR-reduce every word stored. If the bitmap is all zero, skip START..WAIT_DONE and report the cycle after the last word: res=16'h0000, res_err=0, res_valid=1. The ALU sees no alu_start.
- Disabled: an empty bitmap is sent to the ALU, which never completes, so the block reports via the timeout.

Test Plan:
- Single pixel at col 5, row 10, mem latency 1 -> res=16'h1EA5 (lshift 5, dshift 53, both scale bits), res_err=0, exactly 24 mem_rd pulses at base..base+23.
- Single pixel at col 0, row 63 -> res=16'h1800.
- All-ones bitmap -> res=16'h0000; 24 column, 64 top and 64 bottom ready pulses; no channel pulses on consecutive cycles.
- Random mem latency 0-7 with a pixel at col 5, row 10 -> same res=16'h1EA5; the mem_rd to mem_valid ordering is never violated.
- All-zero bitmap:
  - Macro off -> res_valid with res_err=1 after TIMEOUT_CYCLES in WAIT_DONE.
  - Macro on -> res=0, res_err=0, no alu_start.
- rst asserted mid-STREAM, then a new req -> all outputs 0 the next cycle; the following run gives the correct result with no spurious res_valid.
